// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_if
// Purpose  : Handshake and operand/result bundle for seq_divider.
// Ports    : start/dividend/divisor (requester -> divider)
//            busy/done/quotient/remainder/dbz (divider -> requester)
// Modports : master = requester side, slave = divider side
// Revision : 1.0  initial release
// ============================================================================
interface seq_divider_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle unsigned restoring divider, one quotient bit per
//            clock. DW-bit dividend / VW-bit divisor -> DW-bit quotient and
//            VW-bit remainder, with a divide-by-zero flag.
// Ports    : clk    - rising-edge clock
//            rst_n  - synchronous active-low reset
//            bus    - seq_divider_if.slave (start/operands in,
//                     busy/done/quotient/remainder/dbz out, all registered)
// Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  wire            clk,
  input  wire            rst_n,
  seq_divider_if.slave   bus
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_dbz;
  logic          r_zpend;   // divide-by-zero accepted, completion due next edge
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_rem;
  // Dividend shifts out of the MSB while quotient bits shift into the LSB,
  // so after DW iterations this register holds the quotient.
  logic [DW-1:0] r_sr;
  logic [VW-1:0] r_div;
  // Stored partial remainder is always < divisor, so VW bits suffice; the
  // extra (VW+1)th bit only exists transiently in w_p before the subtract.
  logic [VW-1:0] r_part;
  logic [CW-1:0] r_cnt;

  logic [VW:0]   w_p;
  logic          w_ge;
  logic [VW-1:0] w_next_part;
  logic [DW-1:0] w_next_sr;

  always_comb begin
    w_p         = {r_part, r_sr[DW-1]};
    w_ge        = (w_p >= {1'b0, r_div});
    w_next_part = w_ge ? VW'(w_p - {1'b0, r_div}) : w_p[VW-1:0];
    w_next_sr   = {r_sr[DW-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_zpend <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_sr    <= '0;
      r_div   <= '0;
      r_part  <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Deferred divide-by-zero completion, one edge after acceptance.
          if (r_zpend) begin
            r_quot  <= '1;
            r_rem   <= '0;
            r_dbz   <= 1'b1;
            r_done  <= 1'b1;
            r_zpend <= 1'b0;
          end
          if (bus.start) begin
            // A completing zero-divide owns dbz this edge; do not clear it.
            if (!r_zpend) begin
              r_dbz <= 1'b0;
            end
            r_sr   <= bus.dividend;
            r_div  <= bus.divisor;
            r_part <= '0;
            r_cnt  <= CW'(DW - 1);
            if (bus.divisor == '0) begin
              r_zpend <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
          end
        end

        S_CALC: begin
          r_part <= w_next_part;
          r_sr   <= w_next_sr;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_quot  <= w_next_sr;
            r_rem   <= w_next_part;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_rem;
  assign bus.dbz       = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Scoreboard bench for seq_divider. Stimulus pushes expected
//            results (with the edge at which done must appear); a monitor
//            pops and compares on every done pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errs;
  int   checks;

  seq_divider_if #(.DW(8), .VW(4)) bus ();

  seq_divider #(.DW(8), .VW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [7:0] dd;
    logic [3:0] dv;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         due;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient",  32'(bus.quotient),  32'(e.q));
        chk("remainder", 32'(bus.remainder), 32'(e.r));
        chk("dbz",       32'(bus.dbz),       32'(e.z));
        chk("latency",   32'(cyc),           32'(e.due));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        if (!e.z) begin
          // Multiply back: q*d + r must reproduce the dividend, r < d.
          chk("roundtrip", 32'(bus.quotient) * 32'(e.dv) + 32'(bus.remainder), 32'(e.dd));
          chk("rem_lt_div", 32'(bus.remainder < e.dv), 32'd1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one start cycle; returns just after the accepting edge k.
  task automatic issue(input logic [7:0] dd, input logic [3:0] dv,
                       input logic [7:0] q, input logic [3:0] r, input logic z);
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    sb.push_back('{dd: dd, dv: dv, q: q, r: r, z: z, due: cyc + 1 + (z ? 1 : 8)});
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errs++;
      $display("FAIL done_timeout actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic expect_no_done(input string nm, input int ncyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (bus.done !== 1'b0) seen = 1'b1;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    logic bflag;
    errs         = 0;
    checks       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) step();

    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_q",    32'(bus.quotient), 32'd0);
    chk("rst_r",    32'(bus.remainder), 32'd0);
    chk("rst_dbz",  32'(bus.dbz), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic 200/7: busy for 8 cycles, done after k+8, held after k+9
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    bflag = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.busy !== 1'b1) bflag = 1'b0;
      step();
    end
    chk("busy_8_cycles", 32'(bflag), 32'd1);
    chk("busy_dropped", 32'(bus.busy), 32'd0);
    step();
    chk("done_low_k9", 32'(bus.done), 32'd0);
    chk("q_held", 32'(bus.quotient), 32'd28);
    chk("r_held", 32'(bus.remainder), 32'd4);

    // Boundary operands
    issue(8'd255, 4'd1,  8'd255, 4'd0, 1'b0); wait_done();
    issue(8'd255, 4'd15, 8'd17,  4'd0, 1'b0); wait_done();
    issue(8'd5,   4'd15, 8'd0,   4'd5, 1'b0); wait_done();
    issue(8'd0,   4'd9,  8'd0,   4'd0, 1'b0); wait_done();

    // Divide by zero, then a normal division clears dbz
    issue(8'd13, 4'd0, 8'hFF, 4'd0, 1'b1);
    chk("dbz_busy_k",  32'(bus.busy), 32'd0);
    chk("dbz_done_k",  32'(bus.done), 32'd0);
    step();
    chk("dbz_busy_k1", 32'(bus.busy), 32'd0);
    wait_done();
    issue(8'd12, 4'd3, 8'd4, 4'd0, 1'b0); wait_done();

    // Start held high with changing operands during 100/9
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 4'd9;
    sb.push_back('{dd: 8'd100, dv: 4'd9, q: 8'd11, r: 4'd1, z: 1'b0, due: cyc + 9});
    step();
    for (int i = 0; i < 7; i++) begin
      bus.dividend = 8'(i * 37 + 3);
      bus.divisor  = 4'(i * 5);
      step();
    end
    bus.start = 1'b0;
    wait_done();
    expect_no_done("no_extra_done", 4);

    // Back-to-back: start in the done cycle
    issue(8'd60, 4'd4, 8'd15, 4'd0, 1'b0);
    repeat (8) step();
    chk("b2b_first_done", 32'(bus.done), 32'd1);
    issue(8'd77, 4'd5, 8'd15, 4'd2, 1'b0);
    wait_done();

    // Reset at iteration 4 aborts with no done
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_q",    32'(bus.quotient), 32'd0);
    chk("abort_r",    32'(bus.remainder), 32'd0);
    rst_n = 1'b1;
    expect_no_done("abort_no_done", 12);

    // Reset together with start: request ignored
    rst_n        = 1'b0;
    bus.start    = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 4'd3;
    step();
    rst_n     = 1'b1;
    bus.start = 1'b0;
    chk("rst_start_busy", 32'(bus.busy), 32'd0);
    expect_no_done("rst_start_no_done", 12);

    // Exhaustive sweep, dividend 0..255, divisor 1..15
    for (int d = 0; d < 256; d++) begin
      for (int v = 1; v < 16; v++) begin
        issue(8'(d), 4'(v), 8'(d / v), 4'(d % v), 1'b0);
        wait_done();
      end
    end

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
